pipe_register_file: RTL
=======================

PIPE_REGISTER_FILE -- requirements
Module: pipe_register_file

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 64, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, 15, number of architectural registers, maximum 15.
REQ-003 SHALL have parameter RSP_IDX, 4, index of the stack-pointer register.
REQ-004 SHALL have parameter RSP_INIT, 0, reset value of register RSP_IDX.
REQ-005 SHALL have ports (name, direction, width, meaning): clock, in, 1, sole clock, rising-edge active.
REQ-006 SHALL have port reset, in, 1, synchronous, active-high.
REQ-007 SHALL have ports srcA and srcB, in, 4 each, read addresses; 4'hF means RNONE.
REQ-008 SHALL have ports valA and valB, out, DATA_W each, read data.
REQ-009 SHALL have ports dstE, in, 4; valE, in, DATA_W; weE, in, 1: ALU write port.
REQ-010 SHALL have ports dstM, in, 4; valM, in, DATA_W; weM, in, 1: memory write port.
REQ-011 SHALL have ports iss_valid, in, 1; iss_dstE, in, 4; iss_dstM, in, 4: issue of an instruction that will later write.
REQ-012 SHALL have ports hazA and hazB, out, 1 each: the source register has a write pending.
REQ-013 SHALL have port pending, out, NUM_REGS: scoreboard bits.
REQ-014 SHALL have port regs_flat, out, NUM_REGS*DATA_W: register i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-015 SHALL compute valA and valB combinationally, with zero added latency.
REQ-016 SHALL return 0 on a read with address 4'hF or any address >= NUM_REGS.
REQ-017 SHALL bypass same-cycle writes on reads, with priority M write, then E write, then stored value.
REQ-018 SHALL perform writes on the rising clock edge only when the port's we is 1 and its dst < NUM_REGS; otherwise the write is ignored.
REQ-019 SHALL let the M port win when dstE == dstM and both are enabled; the E value is discarded.
REQ-020 SHALL make regs_flat reflect the stored state only, with no bypass, updating one cycle after the write edge.
REQ-021 SHALL set pending[d] at the edge when iss_valid is 1, for each valid d in {iss_dstE, iss_dstM}.
REQ-022 SHALL clear pending[d] at the edge of a completed write to d on either port.
REQ-023 SHALL make set win over clear when a set and a clear target the same bit in the same cycle.
REQ-024 SHALL drive hazA = pending[srcA] & ~(write to srcA this cycle), and likewise hazB; both SHALL be 0 for RNONE or an out-of-range address.
REQ-025 SHALL hold pending bits indefinitely until cleared; there is no timeout.

Reset
REQ-026 SHALL, while reset is 1 at a rising edge, set all registers to 0 except RSP_IDX, which SHALL be set to RSP_INIT.
REQ-027 SHALL clear all pending bits on reset, and reset SHALL override writes and issues in the same cycle.
REQ-028 SHALL force hazA = hazB = 0 and pending = 0 in the cycle after reset.
REQ-029 SHALL keep read ports combinational during reset, returning bypassed or stored values.

Verification
REQ-030 Reset test: RSP_INIT = 64'h100, assert reset for 1 cycle -> regs_flat shows reg4 = 64'h100, all others 0; pending = 0.
REQ-031 Bypass test: weE = 1, dstE = 3, valE = 64'h55, srcA = 3 in the same cycle -> valA = 64'h55 before the edge; reg3 = 64'h55 after it.
REQ-032 Port conflict (popq %rsp case): dstE = dstM = 4, valE = 64'h108, valM = 64'hDEAD, both enabled -> reg4 = 64'hDEAD and same-cycle valA(srcA = 4) = 64'hDEAD.
REQ-033 Scoreboard: iss_valid with iss_dstE = 2 -> pending[2] = 1; next cycle srcB = 2 -> hazB = 1; write dstM = 2 -> hazB = 0 that cycle and pending[2] = 0 after.
REQ-034 Set/clear collision: write to 5 and issue dstE = 5 in the same cycle -> pending[5] = 1 after the edge.
REQ-035 RNONE and reset override: weE = 1, dstE = 4'hF -> no register changes; write to 7 with reset = 1 -> reg7 = 0.

Source files
------------

// File: rtl/pipe_register_file_if.sv
// Register-file port bundle: two read ports, E/M write ports, issue port and scoreboard view.
// The register file sits on the slave side; the pipeline (or bench) drives the master side.
interface pipe_register_file_if #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15
);
    logic [3:0]                 srcA;
    logic [3:0]                 srcB;
    logic [DATA_W-1:0]          valA;
    logic [DATA_W-1:0]          valB;
    logic [3:0]                 dstE;
    logic [DATA_W-1:0]          valE;
    logic                       weE;
    logic [3:0]                 dstM;
    logic [DATA_W-1:0]          valM;
    logic                       weM;
    logic                       iss_valid;
    logic [3:0]                 iss_dstE;
    logic [3:0]                 iss_dstM;
    logic                       hazA;
    logic                       hazB;
    logic [NUM_REGS-1:0]        pending;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;

    modport master (
        output srcA, srcB, dstE, valE, weE, dstM, valM, weM,
               iss_valid, iss_dstE, iss_dstM,
        input  valA, valB, hazA, hazB, pending, regs_flat
    );

    modport slave (
        input  srcA, srcB, dstE, valE, weE, dstM, valM, weM,
               iss_valid, iss_dstE, iss_dstM,
        output valA, valB, hazA, hazB, pending, regs_flat
    );
endinterface

// File: rtl/pipe_register_file.sv
// Pipeline register file: combinational bypassed reads, E/M write ports with M priority,
// and a pending-write scoreboard that flags read hazards.
module pipe_register_file #(
    parameter int                DATA_W   = 64,
    parameter int                NUM_REGS = 15,
    parameter int                RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input logic               clock,
    input logic               reset,
    pipe_register_file_if.slave rf
);
    localparam logic [4:0] LIM = 5'(NUM_REGS);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic                w_wr_e;
    logic                w_wr_m;

    function automatic logic in_range(input logic [3:0] a);
        return {1'b0, a} < LIM;
    endfunction

    // Address 4'hF (RNONE) is always out of range because NUM_REGS never exceeds 15.
    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (in_range(a)) begin
            if (w_wr_m && rf.dstM == a)
                v = rf.valM;
            else if (w_wr_e && rf.dstE == a)
                v = rf.valE;
            else
                v = r_regs[a];
        end
        return v;
    endfunction

    function automatic logic hazard(input logic [3:0] a);
        logic h;
        h = 1'b0;
        if (in_range(a))
            h = r_pending[a] && !((w_wr_m && rf.dstM == a) || (w_wr_e && rf.dstE == a));
        return h;
    endfunction

    assign w_wr_e = rf.weE && in_range(rf.dstE);
    assign w_wr_m = rf.weM && in_range(rf.dstM);

    always_comb begin
        rf.valA = read_port(rf.srcA);
        rf.valB = read_port(rf.srcB);
        rf.hazA = hazard(rf.srcA);
        rf.hazB = hazard(rf.srcB);
    end

    // Issue sets are applied after completion clears so a same-cycle set survives.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr_e)
            w_pending_nxt[rf.dstE] = 1'b0;
        if (w_wr_m)
            w_pending_nxt[rf.dstM] = 1'b0;
        if (rf.iss_valid && in_range(rf.iss_dstE))
            w_pending_nxt[rf.iss_dstE] = 1'b1;
        if (rf.iss_valid && in_range(rf.iss_dstM))
            w_pending_nxt[rf.iss_dstM] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
            r_pending <= '0;
        end else begin
            if (w_wr_e)
                r_regs[rf.dstE] <= rf.valE;
            if (w_wr_m)
                r_regs[rf.dstM] <= rf.valM;
            r_pending <= w_pending_nxt;
        end
    end

    assign rf.pending = r_pending;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign rf.regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end
endmodule
